// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave register file with independent write and read FSMs
module axi4_lite_slave_regfile #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDRESS-1:0]      AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDRESS-1:0]      ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(NUM_REGS * 4);

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  active_q;
  logic [0:0]            wr_state_q, wr_state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_commit, wr_in_range;
  logic [0:0]            rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  aw_hs, w_hs, ar_hs, ar_in_range;

  // Readies come from registered state only, so they stay low through reset and rise one edge after release.
  assign AWREADY = active_q && (wr_state_q == WR_IDLE) && !aw_done_q;
  assign WREADY  = active_q && (wr_state_q == WR_IDLE) && !w_done_q;
  assign ARREADY = active_q && (rd_state_q == RD_IDLE);
  assign BVALID  = (wr_state_q == WR_RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = (rd_state_q == RD_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign ar_hs       = ARVALID && ARREADY;
  assign ar_in_range = (ARADDR < ADDR_LIMIT);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    if (aw_hs) begin
      aw_done_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (w_hs) begin
      w_done_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    wr_in_range = (awaddr_d < ADDR_LIMIT);
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_done_d && w_done_d) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: begin
        if (BREADY) begin
          wr_state_d = WR_IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
    endcase
  end

  // The array is read before this edge's write lands, so a same-edge collision returns the old value.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rdata_d    = ar_in_range ? regs_q[ARADDR[IDX_W+1:2]] : '0;
          rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: begin
        if (RREADY) rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      active_q   <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      active_q   <= 1'b1;
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      if (wr_commit && wr_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb_d[b]) regs_q[awaddr_d[IDX_W+1:2]][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - self-checking bench for axi4_lite_slave_regfile
module tb_axi4_lite_slave_regfile;
  localparam int NUM_REGS = 16;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [NUM_REGS];

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regfile #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  function automatic bit in_range(input logic [31:0] a);
    return a < NUM_REGS * 4;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_range(a) ? model[int'(a / 4)] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = '0;
    for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
    if (in_range(a)) model[int'(a / 4)] = (model[int'(a / 4)] & ~mask) | (d & mask);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_cmp++;
      if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0 || RDATA !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h, required all zero",
                 AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
      end
    end
    ARESET = 1'b0;
    tick();
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_release: aw/w/ar rdy=%b%b%b bv=%b rv=%b, required 111 00",
               AWREADY, WREADY, ARREADY, BVALID, RVALID);
    end
    for (int r = 0; r < NUM_REGS; r++) model[r] = 32'h0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awd, input int wd, input int bhold);
    bit aw_ok = 1'b0, w_ok = 1'b0, aw_hs, w_hs;
    int cyc = 0;
    logic [1:0] b0;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      AWVALID = !aw_ok && cyc >= awd;
      AWADDR  = AWVALID ? addr : $urandom;
      WVALID  = !w_ok && cyc >= wd;
      WDATA   = WVALID ? data : $urandom;
      WSTRB   = WVALID ? strb : 4'($urandom);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      aw_ok = aw_ok | aw_hs;
      w_ok  = w_ok | w_hs;
      cyc++;
      if (!(aw_ok && w_ok)) begin
        n_cmp++;
        if (BVALID !== 1'b0 || AWREADY !== !aw_ok || WREADY !== !w_ok) begin
          n_bad++;
          $display("FAIL wr_wait: bvalid=%b awready=%b wready=%b, required 0 %b %b",
                   BVALID, AWREADY, WREADY, !aw_ok, !w_ok);
        end
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0; AWADDR = $urandom; WDATA = $urandom;
    n_cmp++;
    if (!(aw_ok && w_ok)) begin
      n_bad++;
      $display("FAIL wr_timeout: aw_captured=%b w_captured=%b, required both", aw_ok, w_ok);
      return;
    end
    model_write(addr, data, strb);
    if (BVALID !== 1'b1 || BRESP !== exp_resp(addr)) begin
      n_bad++;
      $display("FAIL wr_bresp: addr=%h bvalid=%b bresp=%b, required 1 %b", addr, BVALID, BRESP, exp_resp(addr));
    end
    b0 = BRESP;
    for (int i = 0; i < bhold; i++) begin
      tick();
      n_cmp++;
      if (BVALID !== 1'b1 || BRESP !== b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_hold: bvalid=%b bresp=%b awready=%b wready=%b, required 1 %b 0 0",
                 BVALID, BRESP, AWREADY, WREADY, b0);
      end
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    n_cmp++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_done: bvalid=%b awready=%b wready=%b, required 0 1 1", BVALID, AWREADY, WREADY);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ard, input int rhold,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
    bit hs = 1'b0, ok = 1'b0;
    int cyc = 0;
    logic [31:0] d0;
    while (!ok && cyc < 40) begin
      ARVALID = cyc >= ard;
      ARADDR  = ARVALID ? addr : $urandom;
      hs = ARVALID && ARREADY;
      tick();
      ok = hs;
      cyc++;
    end
    ARVALID = 1'b0; ARADDR = $urandom;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rd_timeout: no AR handshake within %0d cycles, required one", cyc);
      return;
    end
    if (RVALID !== 1'b1 || RDATA !== exp_d || RRESP !== exp_r || ARREADY !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: addr=%h rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
               addr, RVALID, RDATA, RRESP, ARREADY, exp_d, exp_r);
    end
    d0 = RDATA;
    for (int i = 0; i < rhold; i++) begin
      tick();
      n_cmp++;
      if (RVALID !== 1'b1 || RDATA !== d0 || RRESP !== exp_r || ARREADY !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_hold: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
                 RVALID, RDATA, RRESP, ARREADY, d0, exp_r);
      end
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    n_cmp++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_done: rvalid=%b arready=%b, required 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    axi_read(32'h8, 0, 0, 32'h0, 2'b00);
  endtask

  task automatic test_simultaneous();
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h4, 0, 0, 32'hDEADBEEF, 2'b00);
  endtask

  task automatic test_staggered();
    axi_write(32'h0C, 32'h12345678, 4'hF, 3, 0, 0);
    axi_read(32'h0C, 0, 0, 32'h12345678, 2'b00);
  endtask

  task automatic test_strobes_range();
    axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h10, 32'h000000AA, 4'b0001, 1, 0, 0);
    axi_read(32'h10, 0, 0, 32'hFFFFFFAA, 2'b00);
    axi_write(32'h40, 32'h55AA55AA, 4'hF, 0, 0, 0);
    for (int r = 0; r < NUM_REGS; r++) axi_read(32'(r * 4), 0, 0, exp_rdata(32'(r * 4)), 2'b00);
    axi_read(32'h40, 0, 0, 32'h0, 2'b10);
  endtask

  task automatic test_backpressure();
    axi_write(32'h18, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    axi_read(32'h18, 0, 5, 32'hCAFEF00D, 2'b00);
  endtask

  task automatic test_concurrency();
    logic [31:0] d = $urandom;
    logic [31:0] old = model[5];
    fork
      axi_write(32'h4, d, 4'hF, 0, 0, 1);
      axi_read(32'h0, 0, 2, model[0], 2'b00);
    join
    axi_read(32'h4, 0, 0, d, 2'b00);
    fork
      axi_write(32'h14, ~old, 4'hF, 0, 0, 0);
      axi_read(32'h14, 0, 0, old, 2'b00);
    join
    axi_read(32'h14, 0, 0, ~old, 2'b00);
  endtask

  task automatic test_reset_mid_write();
    int c = 0;
    AWADDR = 32'h8; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && c < 10) begin tick(); c++; end
    tick();
    AWVALID = 1'b0;
    tick();
    n_cmp++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pending: bvalid=%b awready=%b wready=%b, required 0 0 1", BVALID, AWREADY, WREADY);
    end
    apply_reset(1);
    axi_read(32'h8, 0, 0, 32'h0, 2'b00);
    axi_write(32'h8, 32'hA5A5_0001, 4'hF, 3, 0, 0);
    axi_read(32'h8, 0, 0, 32'hA5A5_0001, 2'b00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) axi_write(32'(8 * i), 32'h1000 + 32'(i), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(32'(8 * i), 0, 0, 32'h1000 + 32'(i), 2'b00);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 32'h4F));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), exp_rdata(a), exp_resp(a));
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_staggered();
    test_strobes_range();
    test_backpressure();
    test_concurrency();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite slave register file that terminates the transactions issued by the team's AXI4-Lite master. It holds `NUM_REGS` 32-bit registers behind independent write-channel (AW/W/B) and read-channel (AR/R) state machines. It latches the address and data at each handshake, because the master drives those fields only while VALID is high. It returns OKAY or SLVERR per access.

## Interface
- `ADDRESS`, default 32: AWADDR/ARADDR width.
- `DATA_WIDTH`, default 32: data width; only 32 is supported.
- `NUM_REGS`, default 16: number of registers, power of two, range 2..256.

- `ACLK` in, 1: the single clock; all logic is on the rising edge.
- `ARESET` in, 1: synchronous, active-high reset.
- `AWADDR` in, `ADDRESS`: write address.
- `AWVALID` in, 1: write address valid.
- `AWREADY` out, 1: write address accepted.
- `WDATA` in, `DATA_WIDTH`: write data.
- `WSTRB` in, `DATA_WIDTH/8`: byte enables; tie to 4'b1111 if the master does not drive it.
- `WVALID` in, 1: write data valid.
- `WREADY` out, 1: write data accepted.
- `BRESP` out, 2: write response; 2'b00 OKAY, 2'b10 SLVERR.
- `BVALID` out, 1: write response valid.
- `BREADY` in, 1: master accepts the write response.
- `ARADDR` in, `ADDRESS`: read address.
- `ARVALID` in, 1: read address valid.
- `ARREADY` out, 1: read address accepted.
- `RDATA` out, `DATA_WIDTH`: read data.
- `RRESP` out, 2: read response.
- `RVALID` out, 1: read data valid.
- `RREADY` in, 1: master accepts the read data.

## Operation
- **Address decode.**
  - Word index is `addr[$clog2(NUM_REGS)+1:2]`.
  - `addr[1:0]` is ignored.
  - An address is in range when `addr < NUM_REGS*4`; any other address is out of range and gets SLVERR.
- **Write FSM states:** `WR_IDLE`, `WR_RESP`.
  - In `WR_IDLE`, AWREADY=1 until AW has been captured, and WREADY=1 until W has been captured.
  - AW and W may arrive in either order or in the same cycle.
  - Each handshake latches its payload: AWADDR for AW; WDATA and WSTRB for W.
  - A pending AW or W is held while the other channel is waited for.
  - On the edge where both are captured, in-range writes update only the bytes with WSTRB[i]=1; out-of-range writes are dropped.
  - The FSM then moves to `WR_RESP` with BVALID=1 and BRESP set.
  - In `WR_RESP`, AWREADY=WREADY=0. BVALID and BRESP stay stable until BREADY=1, then the FSM returns to `WR_IDLE` and clears both captured flags.
  - The master may raise BREADY before BVALID. The slave never raises BVALID before both AW and W have been captured.
- **Read FSM states:** `RD_IDLE`, `RD_DATA`.
  - In `RD_IDLE`, ARREADY=1.
  - On an AR handshake, RDATA is loaded from the register array (0 if out of range), RRESP is set, and the FSM moves to `RD_DATA` with RVALID=1 and ARREADY=0.
  - RDATA, RRESP and RVALID stay stable until RREADY=1, then the FSM returns to `RD_IDLE`.
- **Concurrency.** The read and write FSMs are fully independent; a read and a write may be in flight at the same time.
- **Same-edge read/write collision.** When an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value.

## Timing
- **Reset.** While ARESET=1 on a rising edge:
  - AWREADY=WREADY=ARREADY=0.
  - BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0.
  - All registers are cleared to 0 and both FSMs go idle.
  - In the first cycle after release, AWREADY=WREADY=ARREADY=1.
- **Write latency.**
  - AW and W captured on the same edge N: register updated and BVALID=1 after edge N.
  - Staggered AW and W: BVALID=1 after the later capture edge.
  - Minimum write cost is 2 cycles (capture, then B handshake).
- **Read latency.** AR handshake on edge N gives RVALID=1 after edge N; minimum read cost is 2 cycles.
- **Back-to-back.** A new AW/W (or AR) is accepted in the first cycle after the B (or R) handshake. There is no same-cycle overlap.
- **Reset mid-operation.** ARESET aborts any in-flight transaction: BVALID/RVALID drop after the next edge, no response is produced, and a pending write is discarded.
- **Output registering.** Outputs are registered or decoded from state only; there is no combinational path from input to output.

## Test plan
- **Reset defaults:** ARESET high for 3 cycles, then release -> all outputs 0 during reset; AWREADY, WREADY and ARREADY =1 in the first cycle after release; reading 0x8 -> RDATA=0x0, RRESP=00.
- **Simultaneous write, then read:** AW=0x4 and W=0xDEADBEEF with WSTRB=4'hF, same cycle -> BVALID the next cycle, BRESP=00; then read 0x4 -> RDATA=0xDEADBEEF, one cycle after AR handshake.
- **Staggered channels:** W=0x12345678 arrives 3 cycles before AW=0x0C -> WREADY=0 after W capture; BVALID only after AW capture; read 0x0C -> 0x12345678.
- **Byte strobes and out-of-range:**
  - Write 0xFFFFFFFF to 0x10, then 0x000000AA with WSTRB=4'b0001 -> reading 0x10 returns 0xFFFFFFAA.
  - Write 0x40 with NUM_REGS=16 -> BRESP=10 and no register changes.
  - Read 0x40 -> RRESP=10, RDATA=0.
- **Response backpressure and concurrency:**
  - Hold BREADY and RREADY low for 5 cycles -> BVALID/BRESP and RVALID/RDATA stay stable; no new AWREADY or ARREADY until each handshake completes.
  - Concurrent read of 0x0 and write to 0x4 both complete correctly.
- **Reset mid-write:** AW captured, W pending, ARESET pulsed -> no BVALID; the target register is 0 afterwards; the next write completes normally.
